// File: rtl/knn_ctrl_pkg.sv
// knn_ctrl_pkg: shared definitions for the k-nearest-neighbour sequencer.
//   - default parameter values (distance width, K, address and label widths)
//   - FSM state encoding shared by the controller and anything observing it
// The optional majority-vote stage is enabled with `define KNN_CTRL_VOTE_EN.
package knn_ctrl_pkg;

    localparam int unsigned KNN_DEFAULT_DATA_W  = 32;
    localparam int unsigned KNN_DEFAULT_K       = 4;
    localparam int unsigned KNN_DEFAULT_ADDR_W  = 8;
    localparam int unsigned KNN_DEFAULT_LABEL_W = 8;

    // ST_VOTE is only reachable when KNN_CTRL_VOTE_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_VOTE  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // States in which a search is in progress.
    function automatic logic is_busy_state(input state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN) || (s == ST_VOTE);
    endfunction

endpackage

// File: rtl/knn_insert.sv
// knn_insert: combinational compare/shift network for a K-entry ascending list.
//   list_*       : current list, slot 0 (LSBs) is the nearest
//   new_en       : insert request for this cycle
//   new_dist/new_label : candidate entry
//   nxt_*_c      : next list; the candidate goes to the first slot whose
//                  distance is strictly greater, later slots shift down one,
//                  slot K-1 falls off. Unchanged when no slot qualifies.
module knn_insert
    import knn_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = KNN_DEFAULT_DATA_W,
    parameter int unsigned LABEL_W = KNN_DEFAULT_LABEL_W,
    parameter int unsigned K       = KNN_DEFAULT_K
) (
    input  logic [K*DATA_W-1:0]  list_dist,
    input  logic [K*LABEL_W-1:0] list_label,
    input  logic [K-1:0]         list_valid,
    input  logic                 new_en,
    input  logic [DATA_W-1:0]    new_dist,
    input  logic [LABEL_W-1:0]   new_label,
    output logic [K*DATA_W-1:0]  nxt_dist_c,
    output logic [K*LABEL_W-1:0] nxt_label_c,
    output logic [K-1:0]         nxt_valid_c
);

    // Lists moved down one slot: slot j of these holds slot j-1 of the input.
    logic [K*DATA_W-1:0]  sh_dist;
    logic [K*LABEL_W-1:0] sh_label;
    logic [K-1:0]         sh_valid;
    logic [K-1:0]         gt;
    logic [K-1:0]         below;

    assign sh_dist  = list_dist << DATA_W;
    assign sh_label = list_label << LABEL_W;
    assign sh_valid = list_valid << 1;

    // Strict compare keeps an earlier equal-distance point nearer.
    always_comb begin
        gt = '0;
        for (int j = 0; j < int'(K); j++) begin
            gt[j] = new_en && (new_dist < list_dist[j*DATA_W +: DATA_W]);
        end
    end

    // below[j]: insertion point lies strictly before slot j.
    always_comb begin
        below = '0;
        for (int j = 1; j < int'(K); j++) begin
            below[j] = below[j-1] | gt[j-1];
        end
    end

    always_comb begin
        nxt_dist_c  = list_dist;
        nxt_label_c = list_label;
        nxt_valid_c = list_valid;
        for (int j = 0; j < int'(K); j++) begin
            if (below[j]) begin
                nxt_dist_c[j*DATA_W +: DATA_W]    = sh_dist[j*DATA_W +: DATA_W];
                nxt_label_c[j*LABEL_W +: LABEL_W] = sh_label[j*LABEL_W +: LABEL_W];
                nxt_valid_c[j]                    = sh_valid[j];
            end else if (gt[j]) begin
                nxt_dist_c[j*DATA_W +: DATA_W]    = new_dist;
                nxt_label_c[j*LABEL_W +: LABEL_W] = new_label;
                nxt_valid_c[j]                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/knn_ctrl.sv
// knn_ctrl: sequences knn_core over a stored point set and keeps the K
// nearest points to a test point in an ascending register list.
//   clk, rst (sync, active low)
//   start, test_x/test_y, n_points : search request, sampled in IDLE
//   mem_en/mem_addr, mem_x/mem_y/mem_label : point memory, 1-cycle read
//   KNN_ENABLE, KNN_X1/Y1 (test point), KNN_X2/Y2 (memory data), KNN_VALUE
//   busy, done (1-cycle pulse), nb_dist/nb_label/nb_valid (slot 0 nearest)
//   class_label : majority label, only with `define KNN_CTRL_VOTE_EN
// Pipeline: address (stage 1) -> core inputs (stage 2) -> insert (stage 3).
module knn_ctrl
    import knn_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = KNN_DEFAULT_DATA_W,
    parameter int unsigned K       = KNN_DEFAULT_K,
    parameter int unsigned ADDR_W  = KNN_DEFAULT_ADDR_W,
    parameter int unsigned LABEL_W = KNN_DEFAULT_LABEL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DATA_W/2-1:0]    test_x,
    input  logic [DATA_W/2-1:0]    test_y,
    input  logic [ADDR_W:0]        n_points,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W/2-1:0]    mem_x,
    input  logic [DATA_W/2-1:0]    mem_y,
    input  logic [LABEL_W-1:0]     mem_label,
    output logic                   KNN_ENABLE,
    output logic [DATA_W/2-1:0]    KNN_X1,
    output logic [DATA_W/2-1:0]    KNN_Y1,
    output logic [DATA_W/2-1:0]    KNN_X2,
    output logic [DATA_W/2-1:0]    KNN_Y2,
    input  logic [DATA_W-1:0]      KNN_VALUE,
    output logic                   busy,
    output logic                   done,
    output logic [K*DATA_W-1:0]    nb_dist,
    output logic [K*LABEL_W-1:0]   nb_label,
    output logic [K-1:0]           nb_valid
`ifdef KNN_CTRL_VOTE_EN
    ,
    output logic [LABEL_W-1:0]     class_label
`endif
);

    localparam int unsigned CRD_W = DATA_W / 2;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [DATA_W-1:0] KNN_DIST_MAX = '1;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic                   drain_q, drain_d;
    logic [CRD_W-1:0]       tx_q, tx_d;
    logic [CRD_W-1:0]       ty_q, ty_d;
    logic                   mem_en_q, mem_en_d;
    logic                   knn_en_q, knn_en_d;
    logic                   ins_vld_q, ins_vld_d;
    logic [LABEL_W-1:0]     lbl_q, lbl_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [K*DATA_W-1:0]    dist_q, dist_d;
    logic [K*LABEL_W-1:0]   label_q, label_d;
    logic [K-1:0]           valid_q, valid_d;
    logic                   start_ok;

    logic [K*DATA_W-1:0]    ins_dist_c;
    logic [K*LABEL_W-1:0]   ins_label_c;
    logic [K-1:0]           ins_valid_c;

`ifdef KNN_CTRL_VOTE_EN
    logic [LABEL_W-1:0]     class_q, class_d;

    // Majority label over valid slots; a count tie keeps the label seen
    // first while scanning from the nearest slot.
    function automatic logic [LABEL_W-1:0] vote_label(
        input logic [K*LABEL_W-1:0] lbl,
        input logic [K-1:0]         vld
    );
        int unsigned         best_cnt;
        int unsigned         cnt;
        logic [LABEL_W-1:0]  best;
        best     = '0;
        best_cnt = 0;
        for (int j = 0; j < int'(K); j++) begin
            if (vld[j]) begin
                cnt = 0;
                for (int i = 0; i < int'(K); i++) begin
                    if (vld[i] && (lbl[i*LABEL_W +: LABEL_W] == lbl[j*LABEL_W +: LABEL_W])) begin
                        cnt = cnt + 1;
                    end
                end
                if (cnt > best_cnt) begin
                    best_cnt = cnt;
                    best     = lbl[j*LABEL_W +: LABEL_W];
                end
            end
        end
        return best;
    endfunction
`endif

    // Stage 3: merge the returned distance into the sorted list.
    knn_insert #(
        .DATA_W  (DATA_W),
        .LABEL_W (LABEL_W),
        .K       (K)
    ) u_insert (
        .list_dist   (dist_q),
        .list_label  (label_q),
        .list_valid  (valid_q),
        .new_en      (ins_vld_q),
        .new_dist    (KNN_VALUE),
        .new_label   (lbl_q),
        .nxt_dist_c  (ins_dist_c),
        .nxt_label_c (ins_label_c),
        .nxt_valid_c (ins_valid_c)
    );

    // Next-state, address sequencing and list update.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        n_d       = n_q;
        drain_d   = drain_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        mem_en_d  = 1'b0;
        knn_en_d  = mem_en_q;
        ins_vld_d = knn_en_q;
        lbl_d     = knn_en_q ? mem_label : lbl_q;
        dist_d    = ins_dist_c;
        label_d   = ins_label_c;
        valid_d   = ins_valid_c;
        start_ok  = 1'b0;
`ifdef KNN_CTRL_VOTE_EN
        class_d   = class_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_ok = 1'b1;
                    tx_d     = test_x;
                    ty_d     = test_y;
                    n_d      = n_points;
                    addr_d   = '0;
                    drain_d  = 1'b0;
                    if (n_points == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_RUN;
                        mem_en_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (CNT_W'(addr_q) == (n_q - CNT_W'(1))) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d   = addr_q + ADDR_W'(1);
                    mem_en_d = 1'b1;
                end
            end
            // Two cycles let the last point pass stages 2 and 3.
            ST_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
`ifdef KNN_CTRL_VOTE_EN
                    state_d = ST_VOTE;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef KNN_CTRL_VOTE_EN
            ST_VOTE: begin
                class_d = vote_label(label_q, valid_q);
                state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_ok) begin
            dist_d  = {K{KNN_DIST_MAX}};
            label_d = '0;
            valid_d = '0;
`ifdef KNN_CTRL_VOTE_EN
            class_d = '0;
`endif
        end

        busy_d = is_busy_state(state_d);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            n_q       <= '0;
            drain_q   <= 1'b0;
            tx_q      <= '0;
            ty_q      <= '0;
            mem_en_q  <= 1'b0;
            knn_en_q  <= 1'b0;
            ins_vld_q <= 1'b0;
            lbl_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dist_q    <= {K{KNN_DIST_MAX}};
            label_q   <= '0;
            valid_q   <= '0;
`ifdef KNN_CTRL_VOTE_EN
            class_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            n_q       <= n_d;
            drain_q   <= drain_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            mem_en_q  <= mem_en_d;
            knn_en_q  <= knn_en_d;
            ins_vld_q <= ins_vld_d;
            lbl_q     <= lbl_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dist_q    <= dist_d;
            label_q   <= label_d;
            valid_q   <= valid_d;
`ifdef KNN_CTRL_VOTE_EN
            class_q   <= class_d;
`endif
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_addr   = addr_q;
    assign KNN_ENABLE = knn_en_q;
    assign KNN_X1     = tx_q;
    assign KNN_Y1     = ty_q;
    // Memory data goes straight to the core in the cycle it returns.
    assign KNN_X2     = mem_x;
    assign KNN_Y2     = mem_y;
    assign busy       = busy_q;
    assign done       = done_q;
    assign nb_dist    = dist_q;
    assign nb_label   = label_q;
    assign nb_valid   = valid_q;
`ifdef KNN_CTRL_VOTE_EN
    assign class_label = class_q;
`endif

endmodule
